// File: rtl/ripple_count_ctrl.sv
// ripple_count_ctrl: sequencer for an external T flip-flop ripple counter.
// It clears the counter and then issues single count pulses. After each
// pulse it waits a settle window so the ripple can propagate, then samples
// the counter. It stops when the sample equals the captured target.
//
// Optional feature: `define RIPPLE_CTRL_CHECK_EN adds a shadow count. A
// sample that disagrees with the shadow count sets the sticky err flag and
// aborts the run.
//
// Parameters:
//   WIDTH      - width of the ripple counter, target and count_out
//   SETTLE_CYC - clk cycles waited after each pulse before sampling (1..255)
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   start      - level request to begin a run (sampled only when idle)
//   stop       - abort request, honoured in CLEAR/PULSE/SETTLE/CHECK
//   target     - requested final count, captured when start is accepted
//   cnt_q      - parallel outputs of the ripple counter
//   cnt_tick   - count pulse to the counter's first-stage clock
//   cnt_clr_n  - active-low clear to the counter
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse when the target is reached
//   count_out  - last sampled counter value
//   err        - sticky shadow-count mismatch (0 unless CHECK_EN is defined)
module ripple_count_ctrl #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_tick,
    output logic             cnt_clr_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count_out,
    output logic             err
);

    localparam int unsigned SW = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SW-1:0]    r_settle;
    logic [SW-1:0]    w_settle_nxt;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_target_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_tick;
    logic             r_clr_n;
    logic             r_busy;
    logic             r_done;
    logic             w_abortable;

`ifdef RIPPLE_CTRL_CHECK_EN
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic             r_err;
    logic             w_err_nxt;
`endif

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_target_nxt = r_target;
        w_count_nxt  = r_count;
`ifdef RIPPLE_CTRL_CHECK_EN
        w_shadow_nxt = r_shadow;
        w_err_nxt    = r_err;
`endif
        w_abortable  = (r_state == ST_CLEAR) || (r_state == ST_PULSE) ||
                       (r_state == ST_SETTLE) || (r_state == ST_CHECK);

        // stop outranks every other transition, including the CHECK sample
        if (w_abortable && stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
`ifdef RIPPLE_CTRL_CHECK_EN
                        w_err_nxt = 1'b0;
`endif
                        if (target != '0) begin
                            w_target_nxt = target;
                            w_state_nxt  = ST_CLEAR;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_CLEAR: begin
`ifdef RIPPLE_CTRL_CHECK_EN
                    w_shadow_nxt = '0;
`endif
                    w_state_nxt = ST_PULSE;
                end
                ST_PULSE: begin
                    w_settle_nxt = SW'(SETTLE_CYC - 1);
`ifdef RIPPLE_CTRL_CHECK_EN
                    w_shadow_nxt = r_shadow + WIDTH'(1);
`endif
                    w_state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_settle_nxt = r_settle - SW'(1);
                    end
                end
                ST_CHECK: begin
                    w_count_nxt = cnt_q;
`ifdef RIPPLE_CTRL_CHECK_EN
                    if (cnt_q != r_shadow) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else
`endif
                    if (cnt_q == r_target) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_PULSE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register; outputs are decoded from the next state so they align
    // with the state they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_target <= '0;
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_clr_n  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
            r_target <= w_target_nxt;
            r_count  <= w_count_nxt;
            r_tick   <= (w_state_nxt == ST_PULSE);
            r_clr_n  <= (w_state_nxt != ST_CLEAR);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

`ifdef RIPPLE_CTRL_CHECK_EN
    // Shadow count and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
            r_err    <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign cnt_tick  = r_tick;
    assign cnt_clr_n = r_clr_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign count_out = r_count;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Testbench for ripple_count_ctrl. A behavioural ripple counter model feeds
// cnt_q. A timeline model gives the expected outputs for every cycle: each run
// is described by its start cycle and target, and the outputs follow from
// cycle-offset arithmetic.
module tb_ripple_count_ctrl;

    localparam int unsigned W = 4;
    localparam int unsigned S = 3;
    localparam int          P = S + 2;  // cycles per pulse/settle/check round

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         stop;
    logic [W-1:0] target;
    logic [W-1:0] cnt_q;
    logic         cnt_tick;
    logic         cnt_clr_n;
    logic         busy;
    logic         done;
    logic [W-1:0] count_out;
    logic         err;

    ripple_count_ctrl #(.WIDTH(W), .SETTLE_CYC(S)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .target    (target),
        .cnt_q     (cnt_q),
        .cnt_tick  (cnt_tick),
        .cnt_clr_n (cnt_clr_n),
        .busy      (busy),
        .done      (done),
        .count_out (count_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    // External ripple counter: asynchronous clear; counts on each tick.
    // inj_skip makes it jump from 1 to 3.
    logic [W-1:0] ext_cnt = '0;
    logic         inj_skip = 1'b0;
    always @(posedge clk or negedge cnt_clr_n) begin
        if (!cnt_clr_n)
            ext_cnt <= '0;
        else if (cnt_tick)
            ext_cnt <= (inj_skip && ext_cnt == W'(1)) ? W'(3) : ext_cnt + W'(1);
    end
    assign cnt_q = ext_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
        end
    endtask

    // Timeline model: mode 0 idle, 1 run with target>0, 2 target-0 done cycle
    int           n = 0;
    int           m_mode = 0;
    int           m_t0 = 0;
    int           m_tgt = 0;
    logic [W-1:0] m_last = '0;
    bit           model_on = 1'b1;

    function automatic logic [W-1:0] exp_cnt();
        int off;
        off = n - m_t0;
        if (m_mode == 2) return '0;
        if (m_mode == 1 && off >= 2 + P) return W'((off - 2) / P);
        return m_last;
    endfunction

    function automatic logic exp_tick();
        int off;
        off = n - m_t0;
        return (m_mode == 1) && off >= 2 && off < 2 + m_tgt * P && ((off - 2) % P) == 0;
    endfunction

    function automatic logic exp_clr_n();
        return !(m_mode == 1 && (n - m_t0) == 1);
    endfunction

    function automatic logic exp_done();
        return (m_mode == 2) || (m_mode == 1 && (n - m_t0) == 2 + m_tgt * P);
    endfunction

    task automatic model_edge(input logic s, input logic p, input logic [W-1:0] t);
        int off;
        off = n - m_t0;
        case (m_mode)
            0: if (s) begin
                if (t != '0) begin
                    m_mode = 1; m_t0 = n; m_tgt = int'(t);
                end else begin
                    m_mode = 2;
                end
            end
            1: if (off == 2 + m_tgt * P) begin
                m_mode = 0; m_last = W'(m_tgt);
            end else if (p) begin
                m_last = exp_cnt(); m_mode = 0;
            end
            default: begin
                m_mode = 0; m_last = '0;
            end
        endcase
    endtask

    // Directed-test trackers, offsets relative to mark
    int mark, tick_cnt, first_tick, last_tick, clr_cnt, done_cnt, done_at, done_at2;
    logic busy_after;

    task automatic mark_now();
        mark = n; tick_cnt = 0; first_tick = -1; last_tick = -1; clr_cnt = 0;
        done_cnt = 0; done_at = -1; done_at2 = -1; busy_after = 1'b1;
    endtask

    // One clock cycle: inputs apply to cycle n; outputs of cycle n+1 are checked
    task automatic step(input logic s, input logic p, input logic [W-1:0] t);
        start = s; stop = p; target = t;
        @(posedge clk);
        if (model_on) model_edge(s, p, t);
        n++;
        #1;
        if (model_on) begin
            chk("cnt_tick", 32'(cnt_tick), 32'(exp_tick()));
            chk("cnt_clr_n", 32'(cnt_clr_n), 32'(exp_clr_n()));
            chk("busy", 32'(busy), 32'(m_mode != 0));
            chk("done", 32'(done), 32'(exp_done()));
            chk("count_out", 32'(count_out), 32'(exp_cnt()));
            chk("err", 32'(err), 32'd0);
        end
        if (cnt_tick) begin
            tick_cnt++;
            if (first_tick < 0) first_tick = n - mark;
            last_tick = n - mark;
        end
        if (!cnt_clr_n) clr_cnt++;
        if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = n - mark;
            else if (done_at2 < 0) done_at2 = n - mark;
        end
        if (done_at >= 0 && n - mark == done_at + 1) busy_after = busy;
    endtask

    task automatic do_reset(input int ncyc, input bit chk_async);
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; target = '0;
        #1;
        if (chk_async) chk("async_rst_busy", 32'(busy), 32'd0);
        repeat (ncyc) @(posedge clk);
        #1;
        chk("rst_tick", 32'(cnt_tick), 32'd0);
        chk("rst_clr_n", 32'(cnt_clr_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_mode = 0; m_last = '0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; target = '0;
        mark_now();

        // Reset, then clear released one cycle later
        do_reset(3, 1'b0);
        step(0, 0, '0);
        chk("rel_clr_n", 32'(cnt_clr_n), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        // target=5: five ticks 5 cycles apart, done at cycle 27
        mark_now();
        step(1, 0, W'(5));
        repeat (32) step(0, 0, W'($urandom));
        chk("t5_done_at", 32'(done_at), 32'd27);
        chk("t5_ticks", 32'(tick_cnt), 32'd5);
        chk("t5_first_tick", 32'(first_tick), 32'd2);
        chk("t5_last_tick", 32'(last_tick), 32'd22);
        chk("t5_count", 32'(count_out), 32'd5);
        chk("t5_busy_after", 32'(busy_after), 32'd0);

        // target=0: immediate done, no clear, no tick
        mark_now();
        step(1, 0, '0);
        repeat (4) step(0, 0, '0);
        chk("t0_done_at", 32'(done_at), 32'd1);
        chk("t0_ticks", 32'(tick_cnt), 32'd0);
        chk("t0_clears", 32'(clr_cnt), 32'd0);
        chk("t0_count", 32'(count_out), 32'd0);

        // target=15, stop during the settle after the third pulse
        mark_now();
        step(1, 0, W'(15));
        while (n - mark < 14) step(0, 0, W'(15));
        step(0, 1, W'(15));
        chk("stop_busy", 32'(busy), 32'd0);
        repeat (3) step(0, 0, W'(15));
        chk("stop_ticks", 32'(tick_cnt), 32'd3);
        chk("stop_done_at", 32'(done_at), 32'hFFFF_FFFF);
        chk("stop_count", 32'(count_out), 32'd2);
        mark_now();
        step(1, 0, W'(1));
        repeat (9) step(0, 0, W'(1));
        chk("t1_done_at", 32'(done_at), 32'd7);
        chk("t1_clears", 32'(clr_cnt), 32'd1);
        chk("t1_count", 32'(count_out), 32'd1);

        // start held high; target changes from 6 to 2 mid-run
        mark_now();
        step(1, 0, W'(6));
        while (n - mark < 46) step(1, 0, (n - mark >= 10) ? W'(2) : W'(6));
        repeat (3) step(0, 0, '0);
        chk("hold_done_at", 32'(done_at), 32'd32);
        chk("hold_busy_after", 32'(busy_after), 32'd0);
        chk("hold_done_at2", 32'(done_at2), 32'd45);
        chk("hold_dones", 32'(done_cnt), 32'd2);
        chk("hold_ticks", 32'(tick_cnt), 32'd8);
        chk("hold_count", 32'(count_out), 32'd2);

        // Reset asserted in the middle of a run
        mark_now();
        step(1, 0, W'(9));
        repeat (8) step(0, 0, W'(9));
        do_reset(2, 1'b1);

        // Randomized traffic against the timeline model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0), W'($urandom));
        end

`ifdef RIPPLE_CTRL_CHECK_EN
        // Counter skips from 1 to 3: err, no done, back to idle
        do_reset(2, 1'b0);
        model_on = 1'b0;
        inj_skip = 1'b1;
        mark_now();
        step(1, 0, W'(5));
        repeat (20) step(0, 0, W'(5));
        chk("skip_err", 32'(err), 32'd1);
        chk("skip_done_at", 32'(done_at), 32'hFFFF_FFFF);
        chk("skip_busy", 32'(busy), 32'd0);
        chk("skip_count", 32'(count_out), 32'd3);
        inj_skip = 1'b0;
        mark_now();
        step(1, 0, W'(1));
        chk("skip_err_clr", 32'(err), 32'd0);
        repeat (9) step(0, 0, W'(1));
        chk("skip_rerun_done_at", 32'(done_at), 32'd7);
        chk("skip_rerun_count", 32'(count_out), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ripple_count_ctrl.md
Name: ripple_count_ctrl

Overview:
Sequencer for the team's T flip-flop ripple (asynchronous) counter. Clears the counter, then issues single count pulses on the counter's clock input. After each pulse it waits a programmable settle window for the ripple to propagate, then samples the counter outputs. Stops when the sampled value equals a requested target, and reports done.

Parameters:
WIDTH, 4, bit width of the external ripple counter, target and count_out.
SETTLE_CYC, 3, clk cycles waited after each pulse before sampling cnt_q; legal range 1..255.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  level-sampled request to begin a count run; used only in IDLE.
stop  input  1  abort request; honoured in any busy state.
target  input  WIDTH  requested final count; captured when start is accepted.
cnt_q  input  WIDTH  parallel outputs of the external ripple counter.
cnt_tick  output  1  registered count pulse; drives the ripple counter's first-stage clk.
cnt_clr_n  output  1  registered active-low clear; drives the ripple counter's reset_n.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when the target is reached.
count_out  output  WIDTH  last sampled counter value.
err  output  1  sticky mismatch flag; only driven when CHECK_EN is defined, otherwise constant 0.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, cnt_tick=0, cnt_clr_n=0, busy=0, done=0, count_out=0, err=0, settle counter=0, target latch=0.
- States: IDLE, CLEAR, PULSE, SETTLE, CHECK, DONE. All outputs are registered.
- IDLE:
  - cnt_clr_n=1 from the first clk after reset.
  - start=1 with target!=0: latch target, go to CLEAR.
  - start=1 with target==0: count_out=0, go to DONE. No CLEAR cycle and no pulse.
- CLEAR: cnt_clr_n=0 for exactly 1 cycle, then PULSE.
- PULSE: cnt_tick=1 for exactly 1 cycle. Load the settle counter with SETTLE_CYC-1, then go to SETTLE.
- SETTLE: cnt_tick=0. Decrement the settle counter each cycle; when it reaches 0, go to CHECK. Total time in SETTLE is SETTLE_CYC cycles.
- CHECK: count_out<=cnt_q.
  - If cnt_q==latched target: go to DONE.
  - Otherwise: go to PULSE.
- DONE: done=1 for 1 cycle, then IDLE. count_out holds its value.
- Latency: start accepted in cycle 0 (target T>0) gives done high in cycle 2+T*(SETTLE_CYC+2).
- stop=1 in CLEAR, PULSE, SETTLE or CHECK:
  - Next state is IDLE; cnt_tick=0 and cnt_clr_n=1 next cycle.
  - done is not asserted.
  - count_out holds its last sampled value.
  - stop has priority over every other transition in the same cycle.
- stop in IDLE or DONE: ignored.
- start while busy: ignored; target changes while busy are ignored.
- Wrap-around: the target is always reachable within 2^WIDTH-1 pulses, so the counter never wraps during a correct run.
- Reset asserted mid-run: immediate return to reset values. cnt_clr_n=0 also clears the external counter.

Optional Feature:
Macro: RIPPLE_CTRL_CHECK_EN
- Defined:
  - A WIDTH-bit shadow count is cleared in CLEAR and incremented in PULSE.
  - In CHECK, if cnt_q != shadow: err<=1, count_out<=cnt_q, go to IDLE without done.
  - err is sticky until the next accepted start, which clears it.
- Not defined: no shadow register; err is tied to 0; behaviour is otherwise identical.

Test Plan:
- Reset low for 3 cycles, then release → all outputs match reset values; cnt_clr_n=1 one cycle after release; busy=0.
- WIDTH=4, SETTLE_CYC=3, target=5, start pulse in cycle 0 → 5 cnt_tick pulses spaced 5 cycles apart; done high in cycle 27; count_out=5; busy low in cycle 28.
- target=0, start → done high in cycle 1; no cnt_tick and no clear pulse; count_out=0.
- target=15, stop raised in the SETTLE after the 3rd pulse → IDLE next cycle; done never high; count_out=2 (last sample); a following start with target=1 clears the counter and gives done with count_out=1.
- start held high for the whole run with target changed mid-run from 6 to 2 → run ends at 6; a new run starts only after returning to IDLE.
- With RIPPLE_CTRL_CHECK_EN, counter model forced to skip a value (reads 3 after the 2nd pulse) → err=1, no done, IDLE; err cleared on the next start.
